// File: rtl/door_access_pkg.sv
// Shared definitions for the door access arbiter: checker state encodings,
// arbiter FSM states and the keypad code width.
package door_access_pkg;

    localparam int unsigned CODE_W = 4;

    // Encodings of the shared checker's state_out
    localparam logic [1:0] CHK_IDLE    = 2'b00;
    localparam logic [1:0] CHK_CHECK   = 2'b01;
    localparam logic [1:0] CHK_GRANTED = 2'b10;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_EVAL,
        ARB_OPEN,
        ARB_RESP
    } arb_state_e;

endpackage

// File: rtl/door_access_arbiter_rr.sv
// Combinational round-robin picker: grants the first eligible requester at or
// after the pointer, wrapping around N.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] pointer,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index
);

    localparam logic [IW:0] N_W = (IW+1)'(N);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;
    logic          found;

    // Scan from the pointer upward, wrapping once, and take the first hit
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            sum = {1'b0, pointer} + (IW+1)'(k);
            if (sum >= N_W) begin
                sum = sum - N_W;
            end
            cand = sum[IW-1:0];
            if (!found && eligible[cand]) begin
                grant[cand] = 1'b1;
                index       = cand;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/door_access_arbiter.sv
// Shares one keypad access checker among NUM_PORTS requesters: serialises
// requests round-robin, drives the checker, decodes its verdict, and applies
// per-port lockout after repeated denials plus a watchdog against a hung checker.
module door_access_arbiter
    import door_access_pkg::*;
#(
    parameter int unsigned NUM_PORTS   = 4,
    parameter int unsigned MAX_FAILS   = 3,
    parameter int unsigned LOCK_CYCLES = 64,
    parameter int unsigned TIMEOUT     = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS-1:0]          port_req,
    input  logic [CODE_W*NUM_PORTS-1:0]   port_code,
    output logic [NUM_PORTS-1:0]          port_done,
    output logic                          port_ok,
    output logic [NUM_PORTS-1:0]          port_locked,
    output logic                          busy,
    output logic                          err,
    output logic                          chk_validate,
    output logic [CODE_W-1:0]             chk_code,
    input  logic                          chk_door_open,
    input  logic [1:0]                    chk_state
);

    localparam int unsigned IW        = $clog2(NUM_PORTS);
    localparam logic [7:0]  WD_LIMIT  = 8'(TIMEOUT);
    localparam logic [2:0]  FAIL_LIM  = 3'(MAX_FAILS);
    localparam logic [15:0] LOCK_INIT = 16'(LOCK_CYCLES);

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     rr_q, rr_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              seen_q, seen_d;
    logic              result_q, result_d;
    logic [7:0]        wd_q, wd_d;

    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] gnt_oh;
    logic [IW-1:0]        gnt_idx;
    logic [CODE_W-1:0]    gnt_code;
    logic                 abort;

    assign eligible = port_req & ~port_locked;

    rr_arbiter #(
        .N  (NUM_PORTS),
        .IW (IW)
    ) u_rr (
        .eligible (eligible),
        .pointer  (rr_q),
        .grant    (gnt_oh),
        .index    (gnt_idx)
    );

    // Select the winning port's code with a one-hot mux
    always_comb begin
        gnt_code = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (gnt_oh[p]) begin
                gnt_code = port_code[p*CODE_W +: CODE_W];
            end
        end
    end

    // Next-state logic for the arbitration/sequencing FSM and its datapath
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        idx_d    = idx_q;
        code_d   = code_q;
        seen_d   = seen_q;
        result_d = result_q;
        wd_d     = wd_q;
        abort    = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if ((eligible != '0) && (chk_state == CHK_IDLE)) begin
                    idx_d   = gnt_idx;
                    code_d  = gnt_code;
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                seen_d  = 1'b0;
                wd_d    = '0;
                state_d = ARB_EVAL;
            end
            ARB_EVAL: begin
                wd_d = wd_q + 8'd1;
                if (wd_q == WD_LIMIT) begin
                    abort   = 1'b1;
                    state_d = ARB_IDLE;
                end else if (chk_state == CHK_GRANTED) begin
                    wd_d    = '0;
                    state_d = ARB_OPEN;
                end else if (chk_state == CHK_CHECK) begin
                    seen_d = 1'b1;
                end else if ((chk_state == CHK_IDLE) && seen_q) begin
                    result_d = 1'b0;
                    state_d  = ARB_RESP;
                end
            end
            ARB_OPEN: begin
                wd_d = wd_q + 8'd1;
                if (wd_q == WD_LIMIT) begin
                    abort   = 1'b1;
                    state_d = ARB_IDLE;
                end else if (!chk_door_open) begin
                    result_d = 1'b1;
                    state_d  = ARB_RESP;
                end
            end
            ARB_RESP: begin
                rr_d    = (idx_q == IW'(NUM_PORTS - 1)) ? '0 : idx_q + IW'(1);
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // FSM and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            rr_q     <= '0;
            idx_q    <= '0;
            code_q   <= '0;
            seen_q   <= 1'b0;
            result_q <= 1'b0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            idx_q    <= idx_d;
            code_q   <= code_d;
            seen_q   <= seen_d;
            result_q <= result_d;
            wd_q     <= wd_d;
        end
    end

    // Outputs decoded from the registered state
    always_comb begin
        busy         = (state_q != ARB_IDLE);
        chk_validate = (state_q == ARB_ISSUE);
        chk_code     = code_q;
        port_ok      = (state_q == ARB_RESP) && result_q;
        err          = abort;
        port_done    = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            port_done[p] = (state_q == ARB_RESP) && (idx_q == IW'(p));
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        logic [1:0]  fail_q, fail_d;
        logic [15:0] lock_q, lock_d;
        logic [2:0]  fail_inc;

        assign fail_inc       = {1'b0, fail_q} + 3'd1;
        assign port_locked[g] = (lock_q != '0);

        // Count consecutive denials; reaching the limit arms the lockout timer
        always_comb begin
            fail_d = fail_q;
            lock_d = lock_q;
            if (lock_q != '0) begin
                lock_d = lock_q - 16'd1;
            end
            if ((state_q == ARB_RESP) && (idx_q == IW'(g))) begin
                if (result_q) begin
                    fail_d = '0;
                end else if (fail_inc >= FAIL_LIM) begin
                    fail_d = '0;
                    lock_d = LOCK_INIT;
                end else if (fail_q != 2'b11) begin
                    fail_d = fail_inc[1:0];
                end
            end
        end

        // Per-port fail counter and lock timer registers
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                fail_q <= '0;
                lock_q <= '0;
            end else begin
                fail_q <= fail_d;
                lock_q <= lock_d;
            end
        end
    end

endmodule

// File: tb/tb_door_access_arbiter.sv
// Bench for door_access_arbiter: behavioural checker model as environment,
// transaction-level reference model compared every cycle, plus directed tests.
module tb_door_access_arbiter;

    localparam int N    = 4;
    localparam int MAXF = 3;
    localparam int LOCK = 64;
    localparam int TO   = 32;
    localparam int WIN  = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     port_req;
    logic [4*N-1:0]   port_code;
    logic [N-1:0]     port_done;
    logic             port_ok;
    logic [N-1:0]     port_locked;
    logic             busy;
    logic             err;
    logic             chk_validate;
    logic [3:0]       chk_code;
    logic             chk_door_open;
    logic [1:0]       chk_state;
    logic             hang_mode;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    door_access_arbiter #(
        .NUM_PORTS   (N),
        .MAX_FAILS   (MAXF),
        .LOCK_CYCLES (LOCK),
        .TIMEOUT     (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .port_req      (port_req),
        .port_code     (port_code),
        .port_done     (port_done),
        .port_ok       (port_ok),
        .port_locked   (port_locked),
        .busy          (busy),
        .err           (err),
        .chk_validate  (chk_validate),
        .chk_code      (chk_code),
        .chk_door_open (chk_door_open),
        .chk_state     (chk_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit code_valid(input logic [3:0] c);
        return (c == 4'd3) || (c == 4'd5) || (c == 4'd7) || (c == 4'd9);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Environment: single-keypad checker; hang_mode keeps it stuck in CHECK_CODE
    logic [1:0] ck_state;
    logic [3:0] ck_code;
    int         ck_win;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ck_state <= 2'b00;
            ck_code  <= 4'd0;
            ck_win   <= 0;
        end else begin
            case (ck_state)
                2'b00: if (chk_validate) begin
                    ck_code  <= chk_code;
                    ck_state <= 2'b01;
                end
                2'b01: if (!hang_mode) begin
                    if (code_valid(ck_code)) begin
                        ck_state <= 2'b10;
                        ck_win   <= WIN;
                    end else begin
                        ck_state <= 2'b00;
                    end
                end
                2'b10: begin
                    if (ck_win == 1) ck_state <= 2'b00;
                    ck_win <= ck_win - 1;
                end
                default: ck_state <= 2'b00;
            endcase
        end
    end
    assign chk_state     = ck_state;
    assign chk_door_open = (ck_state == 2'b10);

    // Reference model: one transaction at a time, timed by latency arithmetic
    bit         m_active, m_ok, m_hang;
    int         m_start, m_end, m_port, m_rr;
    logic [3:0] m_code;
    int         m_fail[N];
    int         lk_from[N];
    int         lk_to[N];
    int         val_cnt = 0;
    int         door_last = 0;
    int         lock2_cnt = 0;

    always @(negedge clk) begin
        logic [N-1:0] e_done, e_lock, elig;
        bit           e_busy, e_err, e_val, found;
        int           c, p;
        if (!rst_n) begin
            m_active = 0;
            m_rr     = 0;
            for (int i = 0; i < N; i++) begin
                m_fail[i]  = 0;
                lk_from[i] = 1;
                lk_to[i]   = 0;
            end
        end else begin
            c      = cyc;
            e_busy = m_active && (c > m_start);
            e_err  = m_active && (c == m_end) && m_hang;
            e_val  = m_active && (c == m_start + 1);
            e_done = '0;
            if (m_active && (c == m_end) && !m_hang) e_done[m_port] = 1'b1;
            for (int i = 0; i < N; i++) e_lock[i] = (c >= lk_from[i]) && (c <= lk_to[i]);

            check("done", 32'(port_done), 32'(e_done));
            check("busy", 32'(busy), 32'(e_busy));
            check("err", 32'(err), 32'(e_err));
            check("locked", 32'(port_locked), 32'(e_lock));
            check("validate", 32'(chk_validate), 32'(e_val));
            if (e_done != '0) check("ok", 32'(port_ok), 32'(m_ok));
            if (e_val) check("code", 32'(chk_code), 32'(m_code));

            if (chk_validate) val_cnt++;
            if (chk_door_open) door_last = c;
            if (port_locked[2]) lock2_cnt++;

            if (m_active) begin
                if (c == m_end) begin
                    m_active = 0;
                    if (!m_hang) begin
                        m_rr = (m_port + 1) % N;
                        if (m_ok) m_fail[m_port] = 0;
                        else begin
                            m_fail[m_port]++;
                            if (m_fail[m_port] >= MAXF) begin
                                m_fail[m_port]  = 0;
                                lk_from[m_port] = c + 1;
                                lk_to[m_port]   = c + LOCK;
                            end
                        end
                    end
                end
            end else begin
                elig = port_req & ~e_lock;
                if ((elig != '0) && (ck_state == 2'b00)) begin
                    found = 0;
                    p = 0;
                    for (int k = 0; k < N; k++) begin
                        if (!found && elig[(m_rr + k) % N]) begin
                            found = 1;
                            p = (m_rr + k) % N;
                        end
                    end
                    m_active = 1;
                    m_start  = c;
                    m_port   = p;
                    m_code   = port_code[p*4 +: 4];
                    m_hang   = hang_mode;
                    m_ok     = code_valid(m_code);
                    m_end    = m_hang ? c + 2 + TO : (m_ok ? c + 4 + WIN : c + 4);
                end
            end
        end
    end

    int order_q[$];
    int last_done_cyc, last_lat;
    bit last_ok;

    // Raise requests in mask; drop each one the cycle after its port_done
    task automatic serve(input logic [N-1:0] mask, input int budget);
        logic [N-1:0] pending, done_now;
        int start;
        pending  = mask;
        start    = cyc;
        port_req = port_req | mask;
        for (int i = 0; i < budget && pending != '0; i++) begin
            @(negedge clk);
            done_now = port_done & pending;
            for (int b = 0; b < N; b++) begin
                if (done_now[b]) begin
                    order_q.push_back(b);
                    last_done_cyc = cyc;
                    last_ok       = port_ok;
                end
            end
            @(posedge clk);
            #1;
            port_req = port_req & ~done_now;
            pending  = pending & ~done_now;
        end
        check("serve_complete", 32'(pending), 32'd0);
        last_lat = last_done_cyc - start;
    endtask

    function automatic logic [15:0] all_outs();
        return {port_done, port_ok, port_locked, busy, err, chk_validate, chk_code};
    endfunction

    initial begin
        int v0, errs, dones, err_cyc, c0;
        port_req  = '0;
        port_code = '0;
        hang_mode = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'(all_outs()), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All four ports at once, twice: strict rotation from pointer 0
        port_code = {4'd9, 4'd3, 4'd5, 4'd7};
        for (int r = 0; r < 2; r++) begin
            order_q.delete();
            serve(4'hF, 200);
            check("rr_count", 32'(order_q.size()), 32'd4);
            for (int i = 0; i < 4 && i < order_q.size(); i++) check("rr_order", 32'(order_q[i]), 32'(i));
        end

        // Single grant on port 0
        port_code[3:0] = 4'd7;
        serve(4'b0001, 60);
        check("grant_latency", 32'(last_lat), 32'd20);
        check("grant_ok", 32'(last_ok), 32'd1);
        check("done_after_door", 32'(last_done_cyc - door_last), 32'd2);

        // Single deny on port 1
        port_code[7:4] = 4'd2;
        v0 = val_cnt;
        serve(4'b0010, 20);
        check("deny_latency", 32'(last_lat), 32'd4);
        check("deny_ok", 32'(last_ok), 32'd0);
        check("validate_once", 32'(val_cnt - v0), 32'd1);

        // Three denials lock port 2; port 3 served meanwhile, then port 2 after unlock
        port_code[11:8] = 4'd15;
        for (int i = 0; i < 3; i++) begin
            serve(4'b0100, 20);
            check("lock_deny_latency", 32'(last_lat), 32'd4);
        end
        check("lock_rise", 32'(port_locked), 32'b0100);
        port_code[11:8]  = 4'd5;
        port_code[15:12] = 4'd9;
        order_q.delete();
        serve(4'b1100, 300);
        check("lock_order_count", 32'(order_q.size()), 32'd2);
        if (order_q.size() == 2) begin
            check("lock_order_first", 32'(order_q[0]), 32'd3);
            check("lock_order_second", 32'(order_q[1]), 32'd2);
        end
        check("unlock_grant_ok", 32'(last_ok), 32'd1);
        check("lock_duration", 32'(lock2_cnt), 32'd64);

        // Hung checker: watchdog abort with no completion
        hang_mode      = 1'b1;
        port_code[3:0] = 4'd7;
        port_req       = 4'b0001;
        c0 = cyc; errs = 0; dones = 0; err_cyc = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (err) begin
                errs++;
                err_cyc = cyc;
            end
            if (port_done != '0) dones++;
        end
        check("hang_err_count", 32'(errs), 32'd1);
        check("hang_err_time", 32'(err_cyc - c0), 32'd34);
        check("hang_no_done", 32'(dones), 32'd0);
        check("hang_idle", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        port_req  = '0;
        hang_mode = 1'b0;
        repeat (25) @(posedge clk);
        #1;

        // Asynchronous reset while the door is open
        port_code[3:0] = 4'd7;
        port_req       = 4'b0001;
        repeat (8) @(posedge clk);
        #1;
        check("open_busy", 32'(busy), 32'd1);
        check("open_door", 32'(chk_door_open), 32'd1);
        rst_n    = 1'b0;
        #1;
        check("reset_mid_outputs", 32'(all_outs()), 32'd0);
        port_req = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_hold_outputs", 32'(all_outs()), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        port_code[7:4] = 4'd5;
        serve(4'b0010, 60);
        check("post_reset_latency", 32'(last_lat), 32'd20);
        check("post_reset_ok", 32'(last_ok), 32'd1);

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/door_access_arbiter.md
# door_access_arbiter

Round-robin arbiter and sequencer that shares one single-keypad access-check FSM (inputs validate_code/access_code; outputs open_access_door/state_out) among NUM_PORTS keypad requesters. It serialises requests, drives the checker's validate/code inputs, and decodes the checker's state to return an ok/deny result to the winning port. It also enforces a per-port lockout after repeated denials and a watchdog against a hung checker. Sits between the keypad front-ends and the checker instance.

## Interface
- NUM_PORTS, 4, number of requesters (2..8)
- MAX_FAILS, 3, consecutive denials that trigger lockout (1..3)
- LOCK_CYCLES, 64, lockout duration in clk cycles (≤ 2^16−1)
- TIMEOUT, 32, max cycles in EVAL or OPEN before abort (≤ 255)
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- port_req  in  NUM_PORTS  level request, held until matching port_done
- port_code  in  4*NUM_PORTS  4-bit code per port, port i at [4i+3:4i]
- port_done  out  NUM_PORTS  one-cycle completion pulse, one-hot
- port_ok  out  1  result, valid only while any port_done bit is 1 (1=granted)
- port_locked  out  NUM_PORTS  port currently in lockout
- busy  out  1  arbiter not in IDLE
- err  out  1  one-cycle pulse on watchdog abort
- chk_validate  out  1  to checker validate_code
- chk_code  out  4  to checker access_code
- chk_door_open  in  1  from checker open_access_door
- chk_state  in  2  from checker state_out (00 IDLE, 01 CHECK_CODE, 10 ACCESS_GRANTED)

## Operation
- Reset values: all outputs 0, FSM IDLE, rr pointer 0, fail counters 0, lock timers 0, code latch 0.
- FSM states: IDLE, ISSUE, EVAL, OPEN, RESP.
- IDLE: eligible = port_req & ~port_locked. If nonzero and chk_state==00, grant first eligible at or after rr pointer (wrapping); latch port index and its code; → ISSUE. Otherwise stay.
- ISSUE: chk_validate=1 for exactly this cycle; chk_code=latched code; → EVAL. chk_code holds the latched value from ISSUE through EVAL.
- EVAL: chk_state==01 sets seen flag. chk_state==10 → OPEN. chk_state==00 with seen set → RESP, result deny. Watchdog expiry → IDLE, err pulse, no port_done, grantee's fail count unchanged.
- OPEN: wait for chk_door_open==0 → RESP, result ok. Watchdog expiry → IDLE, err pulse.
- RESP: port_done[grantee]=1, port_ok=result; rr pointer = grantee+1 mod NUM_PORTS; → IDLE.
- Fail counter (per port, 2-bit, saturating): ok clears it. A deny increments it; if the increment reaches MAX_FAILS, clear the counter, load the lock timer with LOCK_CYCLES, and assert port_locked.
- Lock timer: decrements every cycle while nonzero; port_locked = (timer != 0).
- A port deasserting req mid-transaction does not abort it; port_done is still issued.
- A locked port's req is ignored, not queued.

## Timing
- Watchdog: counter cleared on entry to EVAL and OPEN; expires when it equals TIMEOUT.
- Deny path: request seen in IDLE at cycle 0, ISSUE at 1, EVAL at 2 (checker reads 01), EVAL at 3 (checker reads 00), RESP at 4; port_done at cycle 4.
- Grant path: chk_state==10 is seen at cycle 3, then OPEN until the checker's 16-cycle open window ends; port_done comes one cycle after chk_door_open falls.
- Back-to-back: the next grant can occur in the IDLE cycle after RESP.
- Lock timing: port_locked rises the cycle after RESP of the MAX_FAILS-th deny. It stays high exactly LOCK_CYCLES cycles.
- Async reset mid-transaction returns everything to reset values immediately; no port_done is issued.

## Structure
- Package door_access_pkg: checker state encodings (CHK_IDLE=2'b00, CHK_CHECK=2'b01, CHK_GRANTED=2'b10), arbiter FSM state enum, CODE_W=4.
- Sub-module rr_arbiter (parameter N; inputs eligible and pointer; outputs one-hot grant and index). It is combinational and instantiated once.
- Per-port fail/lock logic is a generate loop inside the top.

## Test plan
- Single port 0, code 4'd7 → port_done[0] with port_ok=1 after the door window; port_done never precedes chk_door_open falling.
- Port 1, code 4'd2 → port_done[1] with port_ok=0 at cycle 4; chk_validate high exactly one cycle.
- Ports 0–3 all requesting with valid codes → served in order 0,1,2,3. After re-requests, the rr pointer continues from 0; no port is served twice before the others.
- Port 2 sends 3 consecutive codes of 4'd15 → port_locked[2] high for 64 cycles; its req is ignored meanwhile while port 3 is served; after unlock, code 4'd5 is granted.
- chk_state held at 01 by the bench → err pulse after TIMEOUT cycles, no port_done, FSM back to IDLE.
- rst_n asserted during OPEN → all outputs 0 at once, busy=0; next request is handled normally.
